// File: rtl/kbd_pkg.sv
// Shared definitions for the 4x4 matrix keypad scanner: FSM states,
// key map, row drive patterns and small column-decode helpers.
package kbd_pkg;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HOLD,
    ST_RELEASE
  } state_t;

  // Key map indexed by {row, col}; element 0 is row 0 / column 0.
  // Row 3 carries '*' as E and '#' as F.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,   // row 3: c3..c0
    4'hC, 4'h9, 4'h8, 4'h7,   // row 2
    4'hB, 4'h6, 4'h5, 4'h4,   // row 1
    4'hA, 4'h3, 4'h2, 4'h1    // row 0
  };

  // Active-low one-hot row drive, indexed by row number.
  localparam logic [3:0][3:0] ROW_ONEHOT = {
    4'b0111, 4'b1011, 4'b1101, 4'b1110
  };

  localparam logic [3:0] COL_IDLE = 4'b1111;

  // Exactly one column pulled low.
  function automatic logic is_one_key(input logic [3:0] col);
    return ($countones(~col) == 1);
  endfunction

  // Column number of a single-low column pattern.
  function automatic logic [1:0] col_index(input logic [3:0] col);
    case (col)
      4'b1110: return 2'd0;
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] map_key(input logic [1:0] r, input logic [1:0] c);
    return KEY_MAP[{r, c}];
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; resets to all ones
// so an idle (active-low) bus reads as released straight out of reset.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Shift the input through two stages to settle metastability.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      // NOTE: non-blocking so both stages sample pre-edge values; blocking here would collapse the chain to one flop.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: rotates an active-low row drive, debounces a single
// pressed key, emits one code per press on a valid/ready handshake and
// waits for a debounced release before scanning again.
module keypad_scanner
  import kbd_pkg::*;
#(
  parameter int SCAN_TICKS     = 4,
  parameter int DEBOUNCE_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] column,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready
);

  localparam int SW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_TICKS - 1);
  localparam logic [DW-1:0] DB_DONE   = DW'(DEBOUNCE_TICKS);

  logic [3:0]    col_s;
  state_t        state;
  logic [1:0]    row_idx;
  logic [1:0]    row_idx_q1;
  logic [1:0]    row_idx_q2;
  logic [SW-1:0] scan_cnt;
  logic [DW-1:0] db_cnt;
  logic [DW-1:0] db_next;
  logic [1:0]    key_row;
  logic [3:0]    key_col;

  logic col_one;
  logic col_idle;
  logic settled;
  logic slot_free;

  sync_2ff #(.WIDTH(4)) u_col_sync (
    .clk (clk),
    .rst (rst),
    .d   (column),
    .q   (col_s)
  );

  assign col_one   = is_one_key(col_s);
  assign col_idle  = (col_s == COL_IDLE);
  // col_s lags the row drive by the synchronizer depth; only trust it once
  // the row index seen two cycles ago matches the row driven now.
  assign settled   = (row_idx_q2 == row_idx);
  // A consume in the same cycle frees the slot, so a new key may load.
  assign slot_free = !key_valid || key_ready;
  // Saturating increment of the debounce counter.
  assign db_next   = (db_cnt == DB_DONE) ? db_cnt : db_cnt + 1'b1;

  // Delay line of the driven row index, aligned with the column synchronizer.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_idx_q1 <= 2'd0;
      row_idx_q2 <= 2'd0;
    end else begin
      row_idx_q1 <= row_idx;
      row_idx_q2 <= row_idx_q1;
    end
  end

  // Scan / debounce / hold / release FSM with registered row and key outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_SCAN;
      row       <= ROW_ONEHOT[0];
      row_idx   <= 2'd0;
      scan_cnt  <= '0;
      db_cnt    <= '0;
      key_row   <= 2'd0;
      key_col   <= COL_IDLE;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
    end else begin
      if (key_valid && key_ready) key_valid <= 1'b0;

      case (state)
        ST_SCAN: begin
          if (settled && col_one) begin
            key_row <= row_idx;
            key_col <= col_s;
            db_cnt  <= '0;
            state   <= ST_DEBOUNCE;
          end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            row_idx  <= row_idx + 2'd1;
            row      <= ROW_ONEHOT[row_idx + 2'd1];
          end else begin
            scan_cnt <= scan_cnt + 1'b1;
          end
        end

        ST_DEBOUNCE: begin
          if (col_s != key_col) begin
            state <= ST_SCAN;
          end else begin
            db_cnt <= db_next;
            if (db_next == DB_DONE) begin
              state <= ST_HOLD;
              if (slot_free) begin
                key_code  <= map_key(key_row, col_index(key_col));
                key_valid <= 1'b1;
              end
            end
          end
        end

        ST_HOLD: begin
          if (col_idle) begin
            db_cnt <= '0;
            state  <= ST_RELEASE;
          end
        end

        ST_RELEASE: begin
          if (!col_idle) begin
            state <= ST_HOLD;
          end else begin
            db_cnt <= db_next;
            if (db_next == DB_DONE) begin
              state    <= ST_SCAN;
              scan_cnt <= '0;
              row_idx  <= row_idx + 2'd1;
              row      <= ROW_ONEHOT[row_idx + 2'd1];
            end
          end
        end

        default: state <= ST_SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a behavioural keypad matrix drives
// the columns from the row outputs, a monitor records every consumed code,
// and the expected code sequence is built from the key map and press history.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] column;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;

  logic [15:0] pressed;           // bit r*4+c = key at row r, column c held

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] exp_q[$];
  logic [3:0] got_q[$];
  int         valid_rises = 0;
  int         stable_errs = 0;
  logic       prev_valid  = 1'b0;
  logic       prev_cons   = 1'b0;
  logic [3:0] prev_code   = 4'h0;

  // Key legend, row-major: "123A 456B 789C E0FD".
  logic [3:0] legend [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};

  keypad_scanner #(.SCAN_TICKS(4), .DEBOUNCE_TICKS(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .column    (column),
    .row       (row),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready)
  );

  always #5 clk = ~clk;

  // Passive matrix: a held key shorts its column low while its row is driven low.
  always_comb begin
    column = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row[r] && pressed[r*4+c]) column[c] = 1'b0;
  end

  // Handshake monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (key_valid && !prev_valid) valid_rises++;
      if (prev_valid && !prev_cons && key_valid && key_code != prev_code) stable_errs++;
      if (key_valid && key_ready) got_q.push_back(key_code);
    end
    prev_valid = key_valid && !rst;
    prev_cons  = key_valid && key_ready;
    prev_code  = key_code;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [3:0] row_drive(input int i);
    logic [3:0] v;
    v = 4'hF;
    v[i] = 1'b0;
    return v;
  endfunction

  // Returns just after the edge on which row 0 becomes driven.
  task automatic wait_row0();
    logic [3:0] p;
    int n;
    n = 0;
    p = row;
    step();
    while (!(row == 4'b1110 && p != 4'b1110) && n < 40) begin
      p = row;
      step();
      n++;
    end
    check("row0_found", (n < 40), 1);
  endtask

  task automatic hold_key(input int r, input int c, input int cycles);
    pressed = 16'h1 << (r*4 + c);
    step(cycles);
    pressed = '0;
  endtask

  task automatic compare_codes(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({tag, "_code"}, got_q[i], exp_q[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, chg;
    logic [3:0] p;

    pressed   = '0;
    key_ready = 1'b0;
    rst       = 1'b1;
    step(3);
    check("reset_row", row, 4'b1110);
    check("reset_valid", key_valid, 0);
    check("reset_code", key_code, 4'h0);
    rst = 1'b0;

    // Idle rotation: each row held for four cycles, in order 0..3.
    wait_row0();
    for (int k = 0; k < 8; k++)
      for (int t = 0; t < 4; t++) begin
        check("rotate", row, row_drive(k % 4));
        step();
      end

    // Key 1 for 20 cycles, not consumed: one code, held until ready.
    base = valid_rises;
    wait_row0();
    hold_key(0, 0, 20);
    step(40);
    check("k1_valid", key_valid, 1);
    check("k1_code", key_code, 4'h1);
    check("k1_once", valid_rises - base, 1);
    step(20);
    check("k1_still_valid", key_valid, 1);
    key_ready = 1'b1;
    step();
    key_ready = 1'b0;
    check("k1_consumed", key_valid, 0);
    exp_q.push_back(4'h1);

    // Short glitches on key B are ignored, then a stable press is accepted.
    base = valid_rises;
    repeat (6) begin
      hold_key(1, 3, 3);
      step(5);
    end
    step(20);
    check("glitch_no_valid", valid_rises - base, 0);
    hold_key(1, 3, 60);
    step(40);
    check("kB_code", key_code, 4'hB);
    check("kB_valid", key_valid, 1);
    key_ready = 1'b1;
    step();
    key_ready = 1'b0;
    exp_q.push_back(4'hB);

    // Long hold of 5 with ready high: one code; a bounce inside the release
    // window does not produce another.
    key_ready = 1'b1;
    base = got_q.size();
    hold_key(1, 1, 200);
    step(5);
    hold_key(1, 1, 40);
    step(40);
    check("k5_single", got_q.size() - base, 1);
    exp_q.push_back(4'h5);
    hold_key(1, 1, 60);
    step(40);
    check("k5_again", got_q.size() - base, 2);
    exp_q.push_back(4'h5);
    key_ready = 1'b0;

    // Two keys on one row: invalid pattern, scanning continues.
    base = valid_rises;
    chg  = 0;
    pressed = (16'h1 << 8) | (16'h1 << 9);
    p = row;
    for (int i = 0; i < 100; i++) begin
      step();
      if (row != p) chg++;
      p = row;
    end
    pressed = '0;
    step(20);
    check("multi_no_valid", valid_rises - base, 0);
    check("multi_rotates", (chg >= 24), 1);

    // Backpressure: 2 then 4 with ready low keeps 2, 4 is dropped.
    base = valid_rises;
    hold_key(0, 1, 60);
    step(40);
    hold_key(1, 0, 60);
    step(40);
    check("bp_code", key_code, 4'h2);
    check("bp_valid", key_valid, 1);
    check("bp_rises", valid_rises - base, 1);
    key_ready = 1'b1;
    step();
    key_ready = 1'b0;
    check("bp_consumed", key_valid, 0);
    exp_q.push_back(4'h2);
    step(10);

    // Reset during debounce aborts the press.
    wait_row0();
    pressed = 16'h1 << 1;
    step(5);
    rst = 1'b1;
    step();
    check("rst_mid_row", row, 4'b1110);
    check("rst_mid_valid", key_valid, 0);
    pressed = '0;
    step(2);
    rst = 1'b0;
    base = valid_rises;
    step(60);
    check("rst_no_key", valid_rises - base, 0);

    // Randomized presses with optional leading glitches and random ready.
    for (int n = 0; n < 12; n++) begin
      int r, c, len;
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        hold_key($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(1, 3));
        step(30);
      end
      len = $urandom_range(60, 120);
      pressed = 16'h1 << (r*4 + c);
      for (int i = 0; i < len; i++) begin
        key_ready = $urandom_range(0, 1);
        step();
      end
      pressed   = '0;
      key_ready = 1'b1;
      exp_q.push_back(legend[r*4 + c]);
      step(50);
      key_ready = 1'b0;
    end

    check("code_stable_while_valid", stable_errs, 0);
    compare_codes("sequence");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SCAN_TICKS, 4, clock cycles each row stays driven while scanning (minimum 2).
REQ-002 DEBOUNCE_TICKS, 10, consecutive stable cycles required to accept a press or a release (minimum 1).
REQ-003 clk  input  1  system clock; single clock domain, 1 kHz in the board build.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 column  input  4  keypad columns, active-low, asynchronous to clk; bit i is column i.
REQ-006 row  output  4  row drive, active-low one-hot; bit j is row j.
REQ-007 key_code  output  4  hex code of the accepted key.
REQ-008 key_valid  output  1  key_code holds an unconsumed key.
REQ-009 key_ready  input  1  downstream consumer accepts key_code on this cycle.

Function
REQ-010 The block SHALL pass column through a 2-flop synchronizer; all logic below uses the synchronized value (colS).
REQ-011 Key map (row,col -> code) SHALL be: r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: E(*),0,F(#),D.
REQ-012 colS is "one key" only when exactly one bit is 0; colS=1111 is "idle"; any other value is "invalid".
REQ-013 The FSM SHALL have the states SCAN, DEBOUNCE, HOLD and RELEASE.
REQ-014 SCAN: row SHALL rotate 1110->1101->1011->0111->1110, advancing every SCAN_TICKS cycles.
REQ-015 In SCAN, on "one key", the FSM SHALL latch the row index and colS, freeze row, zero the debounce counter, and go to DEBOUNCE.
REQ-016 DEBOUNCE: the counter increments while colS equals the latched value; any mismatch SHALL return to SCAN with row unchanged.
REQ-017 When the counter reaches DEBOUNCE_TICKS, the FSM SHALL go to HOLD and present the mapped code.
- If key_valid=0: key_code is loaded and key_valid asserts on the next cycle.
- If key_valid=1: the new key is dropped and key_code is unchanged.
REQ-018 HOLD: when colS becomes idle, the FSM SHALL zero the counter and go to RELEASE; row stays frozen.
REQ-019 RELEASE: the counter increments while colS is idle; a non-idle value SHALL return to HOLD.
REQ-020 When the RELEASE counter reaches DEBOUNCE_TICKS, the FSM SHALL go to SCAN and resume rotation from the next row.
REQ-021 Handshake: key_valid SHALL stay high, with key_code stable, until a cycle where key_valid=1 and key_ready=1; it drops on the following cycle.
REQ-022 If a load (REQ-017) and a consume (REQ-021) happen in the same cycle, the load SHALL win: key_valid stays 1 and key_code takes the new code.
REQ-023 "invalid" colS in SCAN SHALL be ignored; in DEBOUNCE it SHALL count as a mismatch.
REQ-024 A held key SHALL produce exactly one code, however long it is held.
REQ-025 The SCAN_TICKS counter SHALL wrap to 0 on each row advance.
REQ-026 The debounce counter SHALL saturate at DEBOUNCE_TICKS; counter width is $clog2(DEBOUNCE_TICKS+1).

Reset
REQ-027 While rst=1, the block SHALL go to state SCAN with:
- row=1110, key_code=0, key_valid=0
- both counters 0
- synchronizer flops = 1111
REQ-028 Reset asserted mid-operation, in any state, SHALL abort it within one cycle, with no key emitted afterwards.

Structure
REQ-029 A shared package kbd_pkg SHALL hold:
- the FSM state enum
- the 4x4 key-map constant array
- the row one-hot constants
REQ-030 The synchronizer SHALL be one sub-module, sync_2ff, parameterized by width and with reset value all ones.

Verification
REQ-031 Press at r0/c0 (column=1110 while row=1110) for 20 cycles -> exactly one key_valid with key_code=1; it stays valid until key_ready=1.
REQ-032 Press at r1/c3 with 3-cycle glitches shorter than DEBOUNCE_TICKS -> no key_valid; stable press -> key_code=B.
REQ-033 Hold 5 for 200 cycles with key_ready=1 -> exactly one code 5; the next key is accepted only after 10 idle cycles.
REQ-034 Two columns low (1100) -> no key_valid; row keeps rotating.
REQ-035 key_ready=0, press 2 then 4 -> key_code stays 2; the second key is dropped; key_ready pulse -> key_valid=0.
REQ-036 rst=1 during DEBOUNCE -> next cycle row=1110, key_valid=0; no key is emitted after release.
